// File: rtl/acc_frame.sv
`default_nettype none
// ============================================================================
//  Module   : acc_frame
//  Purpose  : Frame accumulator. Adds a stream of unsigned N-bit operands
//             (valid/ready handshake) into a running sum with carry-out
//             tracked as a sticky overflow flag. A frame ends after CNT
//             operands or on an accepted in_last; the total is then held
//             until the consumer takes it (out_valid/out_ready).
//  Options  : ACC_FRAME_SAT_EN - when defined, the sum saturates at 2^N-1
//             on any carry; otherwise it wraps modulo 2^N.
//  Ports    : clk, rst_n (async, active-low)
//             in_valid/in_ready/in_data/in_last  - operand stream
//             out_valid/out_ready                - result handshake
//             out_sum/out_ovf/out_count          - frame sum, sticky carry,
//                                                  operands in frame
//  Revision : 1.0 - initial release
// ============================================================================
module acc_frame #(
  parameter  int N   = 16,
  parameter  int CNT = 8,
  localparam int CW  = $clog2(CNT + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_sum,
  output logic          out_ovf,
  output logic [CW-1:0] out_count
);

  localparam logic [0:0] S_ACC  = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [N-1:0]  acc_q,   acc_d;
  logic          ovf_q,   ovf_d;
  logic [CW-1:0] cnt_q,   cnt_d;

  logic          w_accept;
  logic          w_out_fire;
  logic          w_carry;
  logic [N-1:0]  w_sum;
  logic [N-1:0]  w_acc_next;
  logic [CW-1:0] w_cnt_inc;
  logic          w_frame_end;

  assign in_ready  = (state_q == S_ACC);
  assign out_valid = (state_q == S_HOLD);

  assign w_accept   = in_valid && in_ready;
  assign w_out_fire = out_valid && out_ready;

  // Same {carry, sum} = a + b + cin arithmetic as the upstream adder, cin = 0.
  assign {w_carry, w_sum} = {1'b0, acc_q} + {1'b0, in_data};

`ifdef ACC_FRAME_SAT_EN
  // Once saturated, any further non-zero operand carries again, so the
  // value stays pinned at all ones without needing a separate sticky bit.
  assign w_acc_next = w_carry ? {N{1'b1}} : w_sum;
`else
  assign w_acc_next = w_sum;
`endif

  assign w_cnt_inc = cnt_q + CW'(1);

  // in_last on the CNT-th operand is still one frame end: both terms just OR.
  assign w_frame_end = in_last || (w_cnt_inc == CW'(CNT));

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    if (state_q == S_ACC) begin
      if (w_accept) begin
        acc_d = w_acc_next;
        ovf_d = ovf_q | w_carry;
        cnt_d = w_cnt_inc;
        if (w_frame_end) begin
          state_d = S_HOLD;
        end
      end
    end else begin
      if (w_out_fire) begin
        acc_d   = '0;
        ovf_d   = 1'b0;
        cnt_d   = '0;
        state_d = S_ACC;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_ACC;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  // Results come straight from the state registers, so they are stable for
  // the whole HOLD period.
  assign out_sum   = acc_q;
  assign out_ovf   = ovf_q;
  assign out_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_acc_frame.sv
`default_nettype none
// ============================================================================
//  Module   : tb_acc_frame
//  Purpose  : Self-checking bench for acc_frame (N = 16, CNT = 4).
//             Table-driven directed vectors, hand-written multi-cycle
//             sequences, and a randomized run against a frame-level model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_acc_frame;

  localparam int N   = 16;
  localparam int CNT = 4;
  localparam int CW  = 3;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_sum;
  logic          out_ovf;
  logic [CW-1:0] out_count;

  int n_assert;
  int n_fail;

  acc_frame #(.N(N), .CNT(CNT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .out_count (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          v;
    logic [N-1:0]  d;
    logic          l;
    logic          r;
    logic          ev;   // expected out_valid after the edge
    logic [N-1:0]  es;
    logic          eo;
    logic [CW-1:0] ec;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic v, logic [N-1:0] d, logic l, logic r,
                              logic ev, logic [N-1:0] es, logic eo,
                              logic [CW-1:0] ec);
    vec_t t;
    t.v = v; t.d = d; t.l = l; t.r = r;
    t.ev = ev; t.es = es; t.eo = eo; t.ec = ec;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [N-1:0] d, input logic l,
                       input logic r);
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    out_ready = r;
  endtask

  // Apply inputs, clock once, sample 1 time unit after the edge.
  task automatic cyc(input logic v, input logic [N-1:0] d, input logic l,
                     input logic r);
    drive(v, d, l, r);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_result(input string name, input logic [N-1:0] s,
                            input logic o, input logic [CW-1:0] c);
    chk({name, ".valid"}, {31'd0, out_valid}, 32'd1);
    chk({name, ".ready"}, {31'd0, in_ready}, 32'd0);
    chk({name, ".sum"},   {16'd0, out_sum}, {16'd0, s});
    chk({name, ".ovf"},   {31'd0, out_ovf}, {31'd0, o});
    chk({name, ".count"}, {29'd0, out_count}, {29'd0, c});
  endtask

  task automatic chk_idle(input string name);
    chk({name, ".valid"}, {31'd0, out_valid}, 32'd0);
    chk({name, ".ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic do_reset();
    drive(1'b0, '0, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Frame-level reference: sum the accepted operands as plain integers.
  int            m_q[$];
  bit            m_hold;
  logic [N-1:0]  m_sum;
  logic          m_ovf;
  logic [CW-1:0] m_cnt;

  function automatic void model_close();
    longint total;
    total = 0;
    foreach (m_q[i]) total += m_q[i];
    m_ovf = (total >= 65536);
`ifdef ACC_FRAME_SAT_EN
    m_sum = m_ovf ? 16'hFFFF : total[N-1:0];
`else
    m_sum = total[N-1:0];
`endif
    m_cnt = CW'(m_q.size());
  endfunction

  logic [N-1:0] ovf_sum_exp;

  initial begin
    n_assert = 0;
    n_fail   = 0;
`ifdef ACC_FRAME_SAT_EN
    ovf_sum_exp = 16'hFFFF;
`else
    ovf_sum_exp = 16'h0001;
`endif

    // ---------------- reset state ----------------
    drive(1'b0, '0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("reset.valid", {31'd0, out_valid}, 32'd0);
    chk("reset.ready", {31'd0, in_ready}, 32'd1);
    chk("reset.sum",   {16'd0, out_sum}, 32'd0);
    chk("reset.ovf",   {31'd0, out_ovf}, 32'd0);
    chk("reset.count", {29'd0, out_count}, 32'd0);
    do_reset();

    // ---------------- directed table ----------------
    // basic frame 1,2,3,4 then handshake (data ignored in HOLD)
    tbl.push_back(mk(1, 16'd1, 0, 1, 0, 16'd0, 0, 3'd0));
    tbl.push_back(mk(1, 16'd2, 0, 1, 0, 16'd0, 0, 3'd0));
    tbl.push_back(mk(1, 16'd3, 0, 1, 0, 16'd0, 0, 3'd0));
    tbl.push_back(mk(1, 16'd4, 0, 1, 1, 16'd10, 0, 3'd4));
    tbl.push_back(mk(1, 16'd99, 0, 1, 0, 16'd0, 0, 3'd0));
    // early end 5, 7+last
    tbl.push_back(mk(1, 16'd5, 0, 1, 0, 16'd0, 0, 3'd0));
    tbl.push_back(mk(1, 16'd7, 1, 1, 1, 16'd12, 0, 3'd2));
    tbl.push_back(mk(0, 16'd0, 0, 1, 0, 16'd0, 0, 3'd0));
    // overflow
    tbl.push_back(mk(1, 16'hFFFF, 0, 1, 0, 16'd0, 0, 3'd0));
    tbl.push_back(mk(1, 16'h0002, 0, 1, 0, 16'd0, 0, 3'd0));
    tbl.push_back(mk(1, 16'h0000, 0, 1, 0, 16'd0, 0, 3'd0));
    tbl.push_back(mk(1, 16'h0000, 0, 1, 1, ovf_sum_exp, 1, 3'd4));
    tbl.push_back(mk(0, 16'd0, 0, 1, 0, 16'd0, 0, 3'd0));
    // in_last on the CNT-th operand: one frame, nothing extra afterwards
    tbl.push_back(mk(1, 16'd1, 0, 1, 0, 16'd0, 0, 3'd0));
    tbl.push_back(mk(1, 16'd1, 0, 1, 0, 16'd0, 0, 3'd0));
    tbl.push_back(mk(1, 16'd1, 0, 1, 0, 16'd0, 0, 3'd0));
    tbl.push_back(mk(1, 16'd1, 1, 1, 1, 16'd4, 0, 3'd4));
    tbl.push_back(mk(0, 16'd0, 0, 1, 0, 16'd0, 0, 3'd0));
    tbl.push_back(mk(0, 16'd0, 0, 1, 0, 16'd0, 0, 3'd0));
    // single-operand frame via in_last
    tbl.push_back(mk(1, 16'd300, 1, 0, 1, 16'd300, 0, 3'd1));
    tbl.push_back(mk(0, 16'd0, 0, 1, 0, 16'd0, 0, 3'd0));

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].r);
      chk($sformatf("tbl%0d.valid", i), {31'd0, out_valid}, {31'd0, tbl[i].ev});
      chk($sformatf("tbl%0d.ready", i), {31'd0, in_ready}, {31'd0, ~tbl[i].ev});
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d.sum", i),   {16'd0, out_sum}, {16'd0, tbl[i].es});
        chk($sformatf("tbl%0d.ovf", i),   {31'd0, out_ovf}, {31'd0, tbl[i].eo});
        chk($sformatf("tbl%0d.count", i), {29'd0, out_count}, {29'd0, tbl[i].ec});
      end
    end

    // ---------------- output backpressure ----------------
    for (int i = 0; i < 4; i++) cyc(1, 16'd1, 0, 0);
    chk_result("bp.full", 16'd4, 1'b0, 3'd4);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 16'd9, 0, 0);
      chk_result($sformatf("bp.hold%0d", i), 16'd4, 1'b0, 3'd4);
    end
    cyc(1, 16'd9, 0, 1);
    chk_idle("bp.release");
    cyc(1, 16'd9, 1, 0);
    chk_result("bp.next", 16'd9, 1'b0, 3'd1);
    cyc(0, 16'd0, 0, 1);

    // ---------------- reset mid-frame ----------------
    cyc(1, 16'd3, 0, 1);
    cyc(1, 16'd4, 0, 1);
    drive(0, 16'd0, 0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst.sum",   {16'd0, out_sum}, 32'd0);
    chk("rst.count", {29'd0, out_count}, 32'd0);
    chk("rst.ovf",   {31'd0, out_ovf}, 32'd0);
    chk("rst.ready", {31'd0, in_ready}, 32'd1);
    chk("rst.valid", {31'd0, out_valid}, 32'd0);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1, 16'd2, 0, 1);
      chk_idle($sformatf("rst.acc%0d", i));
    end
    cyc(1, 16'd2, 0, 1);
    chk_result("rst.frame", 16'd8, 1'b0, 3'd4);
    cyc(0, 16'd0, 0, 1);

    // ---------------- input stalls ----------------
    for (int i = 1; i <= 4; i++) begin
      cyc(1, 16'(10 * i), 0, 1);
      if (i < 4) begin
        chk_idle($sformatf("stall.acc%0d", i));
        for (int j = 0; j < 2; j++) begin
          cyc(0, 16'hBEEF, 1, 1);
          chk_idle($sformatf("stall.gap%0d_%0d", i, j));
        end
      end
    end
    chk_result("stall.frame", 16'd100, 1'b0, 3'd4);
    cyc(0, 16'd0, 0, 1);

    // ---------------- randomized vs frame-level model ----------------
    do_reset();
    m_q.delete();
    m_hold = 0;
    for (int k = 0; k < 500; k++) begin
      logic          v, l, r;
      logic [N-1:0]  d;
      v = ($urandom_range(0, 3) != 0);
      l = ($urandom_range(0, 5) == 0);
      r = ($urandom_range(0, 1) == 1);
      d = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hC000, 16'hFFFF))
                                      : 16'($urandom);
      if (!m_hold) begin
        if (v) begin
          m_q.push_back(int'(d));
          if (l || m_q.size() == CNT) begin
            model_close();
            m_hold = 1;
          end
        end
      end else if (r) begin
        m_hold = 0;
        m_q.delete();
      end
      cyc(v, d, l, r);
      chk($sformatf("rnd%0d.valid", k), {31'd0, out_valid}, {31'd0, m_hold});
      chk($sformatf("rnd%0d.ready", k), {31'd0, in_ready}, {31'd0, !m_hold});
      if (m_hold) begin
        chk($sformatf("rnd%0d.sum", k),   {16'd0, out_sum}, {16'd0, m_sum});
        chk($sformatf("rnd%0d.ovf", k),   {31'd0, out_ovf}, {31'd0, m_ovf});
        chk($sformatf("rnd%0d.count", k), {29'd0, out_count}, {29'd0, m_cnt});
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
